// File: rtl/irq_pkg.sv
// Shared definitions for the parametrised SM83 interrupt controller:
// register-select encoding, dispatch state enum and a width helper.
package irq_pkg;

   localparam logic IF_SEL = 1'b0;
   localparam logic IE_SEL = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      DISP = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/irq_ctrl_n_if.sv
// Bus between the interrupt controller and the core: request lines,
// IF/IE register port, IME controls and the dispatch handshake.
interface irq_ctrl_n_if #(
   parameter int NUM_IRQ = 8
);
   logic [NUM_IRQ-1:0] CPU_IRQ_TRIG;
   logic               REG_WE;
   logic               REG_SEL;
   logic [NUM_IRQ-1:0] REG_DIN;
   logic [NUM_IRQ-1:0] REG_DOUT;
   logic               IME_EI;
   logic               IME_DI;
   logic               IME_RETI;
   logic               INSTR_DONE;
   logic               DISP_START;
   logic               DISP_ACK;
   logic               IRQ_PENDING;
   logic               WAKE;
   logic               IME;
   logic [15:0]        VECTOR;
   logic               ACK_V;
   logic [NUM_IRQ-1:0] CPU_IRQ_ACK;

   modport master (
      output CPU_IRQ_TRIG, REG_WE, REG_SEL, REG_DIN,
             IME_EI, IME_DI, IME_RETI, INSTR_DONE, DISP_START, DISP_ACK,
      input  REG_DOUT, IRQ_PENDING, WAKE, IME, VECTOR, ACK_V, CPU_IRQ_ACK
   );

   modport slave (
      input  CPU_IRQ_TRIG, REG_WE, REG_SEL, REG_DIN,
             IME_EI, IME_DI, IME_RETI, INSTR_DONE, DISP_START, DISP_ACK,
      output REG_DOUT, IRQ_PENDING, WAKE, IME, VECTOR, ACK_V, CPU_IRQ_ACK
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; bit 0 is the highest priority.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan downwards so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl_n.sv
// Interrupt controller: IF/IE registers, IME with delayed EI, live
// fixed-priority arbitration and a two-phase dispatch with the sequencer.
module irq_ctrl_n
   import irq_pkg::*;
#(
   parameter int          NUM_IRQ    = 8,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
   input logic         CLK,
   input logic         SYNC_RESET,
   irq_ctrl_n_if.slave bus
);

   localparam int IDX_W = (clog2(NUM_IRQ) < 1) ? 1 : clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0] if_q;
   logic [NUM_IRQ-1:0] ie_q;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] ack_mask;
   logic [NUM_IRQ-1:0] if_next;
   logic               ime_q;
   logic               ei_pend_q;
   logic               irq_pending;
   state_t             state;
   state_t             state_next;
   logic               disp_enter;
   logic               disp_done;
   logic [IDX_W-1:0]   win_idx;
   logic               win_vld;
   logic [15:0]        win_vector;
   logic               ack_v_q;
   logic [NUM_IRQ-1:0] irq_ack_q;
   logic [15:0]        vector_q;

   assign pend = if_q & ie_q;

   irq_prio_enc #(.N(NUM_IRQ)) u_prio (
      .req   (pend),
      .idx   (win_idx),
      .valid (win_vld)
   );

   assign win_vector  = VEC_BASE + (16'(win_idx) * VEC_STRIDE);
   assign irq_pending = ime_q & (|pend) & (state == IDLE);

   assign bus.IRQ_PENDING = irq_pending;
   assign bus.WAKE        = |pend;
   assign bus.IME         = ime_q;
   assign bus.REG_DOUT    = (bus.REG_SEL == IE_SEL) ? ie_q : if_q;
   assign bus.ACK_V       = ack_v_q;
   assign bus.CPU_IRQ_ACK = irq_ack_q;
   assign bus.VECTOR      = vector_q;

   always_comb begin
      state_next = state;
      disp_enter = 1'b0;
      disp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.DISP_START && irq_pending) begin
               state_next = DISP;
               disp_enter = 1'b1;
            end
         end
         DISP: begin
            if (bus.DISP_ACK) begin
               state_next = IDLE;
               disp_done  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // IF priority: register write, then ack clear, then new triggers on top.
   always_comb begin
      ack_mask = '0;
      if (disp_done && win_vld) ack_mask[win_idx] = 1'b1;
      if_next = (bus.REG_WE && bus.REG_SEL == IF_SEL) ? bus.REG_DIN : if_q;
      if_next = (if_next & ~ack_mask) | bus.CPU_IRQ_TRIG;
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RESET) state <= IDLE;
      else            state <= state_next;
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RESET) begin
         if_q <= '0;
         ie_q <= '0;
      end else begin
         if_q <= if_next;
         if (bus.REG_WE && bus.REG_SEL == IE_SEL) ie_q <= bus.REG_DIN;
      end
   end

   // DI and dispatch entry both kill a pending EI; a repeated EI is a no-op.
   always_ff @(posedge CLK) begin
      if (SYNC_RESET) begin
         ime_q     <= 1'b0;
         ei_pend_q <= 1'b0;
      end else if (bus.IME_DI || disp_enter) begin
         ime_q     <= 1'b0;
         ei_pend_q <= 1'b0;
      end else begin
         if (bus.IME_RETI) ime_q <= 1'b1;
         if (bus.IME_EI && !ei_pend_q) begin
            ei_pend_q <= 1'b1;
         end else if (ei_pend_q && bus.INSTR_DONE) begin
            ime_q     <= 1'b1;
            ei_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RESET) begin
         ack_v_q   <= 1'b0;
         irq_ack_q <= '0;
         vector_q  <= 16'h0000;
      end else begin
         ack_v_q   <= disp_done;
         irq_ack_q <= ack_mask;
         if (disp_done) vector_q <= win_vld ? win_vector : 16'h0000;
      end
   end

endmodule
